// File: rtl/qos_vc_arbiter.sv
// qos_vc_arbiter: weighted round-robin scheduler that shares one downstream
// link among the 4 virtual-channel FIFOs of the QoS module.
// It issues one-hot FIFO pops and tags each output beat with its channel ID.
// Define QOS_ARB_STRICT_PRIO_EN to replace round-robin with strict
// lowest-index-first priority. Burst lengths are still bounded by the weights.
module qos_vc_arbiter #(
    parameter int                      WEIGHT_W = 4,
    parameter logic [4*WEIGHT_W-1:0]   WEIGHTS  = 16'h1124
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] empty,
    input  logic [3:0] pause_stb,
    input  logic [3:0] continue_stb,
    input  logic       out_ready,
    output logic [3:0] pop,
    output logic [3:0] gnt,
    output logic       valid_out,
    output logic [1:0] vc_id,
    output logic [3:0] paused
);

    typedef enum logic {ARB, BURST} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cur, last, pick;
    logic                found;
    logic [WEIGHT_W-1:0] count;
    logic [3:0]          eligible;
    logic                fire, burst_end;

    // A weight of zero still grants one pop, so no channel can be starved by configuration.
    function automatic logic [WEIGHT_W-1:0] weight_of(input logic [1:0] ch);
        logic [WEIGHT_W-1:0] w;
        w = WEIGHTS[ch*WEIGHT_W +: WEIGHT_W];
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    assign eligible  = ~empty & ~paused;
    assign fire      = (state == BURST) & enable & eligible[cur] & out_ready;
    assign burst_end = (fire && count == WEIGHT_W'(1)) || !eligible[cur] || !enable;

    // Choose the next burst owner among the eligible channels.
`ifdef QOS_ARB_STRICT_PRIO_EN
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        found = 1'b0;
        pick  = 2'd0;
        // Scanning downward lets the lowest eligible index win.
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_idx;
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        found  = 1'b0;
        pick   = 2'd0;
        rr_idx = 2'd0;
        // Scanning from last+4 down to last+1 lets the channel right after 'last' win.
        for (int k = 4; k >= 1; k--) begin
            rr_idx = last + 2'(k);
            if (eligible[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= ARB;
        else       state <= state_nxt;
    end

    // Next-state logic. ARB always lasts exactly one cycle when there is work to grant.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (enable && found) state_nxt = BURST;
            BURST:   if (burst_end)       state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Output logic: pop only the owner, gated by current-cycle empty, pause, enable and ready.
    always_comb begin
        pop = 4'b0000;
        if (fire && !reset) pop = 4'b0001 << cur;
    end

    // Burst bookkeeping: owner, grant, remaining pop budget and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cur   <= 2'd0;
            gnt   <= 4'b0000;
            count <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                ARB: begin
                    if (enable && found) begin
                        cur   <= pick;
                        gnt   <= 4'b0001 << pick;
                        count <= weight_of(pick);
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        last <= cur;
                        gnt  <= 4'b0000;
                    end else if (fire) begin
                        count <= count - WEIGHT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pause tracking. When both strobes arrive together, pause wins.
    always_ff @(posedge CLK) begin
        if (reset) paused <= 4'b0000;
        else       paused <= (paused & ~continue_stb) | pause_stb;
    end

    // Output beat tagging, one cycle after the pop. vc_id holds between beats.
    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_out <= 1'b0;
            vc_id     <= 2'd0;
        end else begin
            valid_out <= |pop;
            if (|pop) vc_id <= cur;
        end
    end

endmodule

// File: tb/tb_qos_vc_arbiter.sv
// tb_qos_vc_arbiter: self-checking bench for qos_vc_arbiter.
// A cycle-level reference model predicts pop/gnt/paused. The expected channel
// of every beat is queued when its pop is predicted and compared when valid_out appears.
// The bench follows QOS_ARB_STRICT_PRIO_EN if it is defined.
module tb_qos_vc_arbiter;

`ifdef QOS_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    localparam logic [15:0] TB_WEIGHTS = 16'h1124;

    logic       CLK;
    logic       reset, enable, out_ready;
    logic [3:0] empty, pause_stb, continue_stb;
    logic [3:0] pop, gnt, paused;
    logic       valid_out;
    logic [1:0] vc_id;

    qos_vc_arbiter #(.WEIGHT_W(4), .WEIGHTS(TB_WEIGHTS)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .empty(empty),
        .pause_stb(pause_stb), .continue_stb(continue_stb), .out_ready(out_ready),
        .pop(pop), .gnt(gnt), .valid_out(valid_out), .vc_id(vc_id), .paused(paused)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_burst;
    int         m_owner, m_left, m_last;
    logic [3:0] m_gnt, m_paused, m_pop;
    bit         m_valid;
    int         m_vc;
    int         exp_q[$];
    logic [3:0] seen_pop;

    function automatic int enc(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int weight(input int ch);
        int w;
        w = int'((TB_WEIGHTS >> (4 * ch)) & 16'hF);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [3:0] model_pop();
        if (reset) return 4'b0000;
        if (m_burst && enable && !empty[m_owner] && !m_paused[m_owner] && out_ready)
            return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_edge();
        logic [3:0] elig;
        bit         popped, got;
        int         c;
        if (reset) begin
            m_burst = 0; m_last = 3; m_paused = 4'b0; m_gnt = 4'b0;
            m_valid = 0; m_vc = 0; exp_q.delete();
            return;
        end
        elig    = ~empty & ~m_paused;
        popped  = (m_pop != 4'b0);
        m_valid = popped;
        if (popped) m_vc = enc(m_pop);
        if (!m_burst) begin
            got = 0;
            if (enable) begin
                for (int n = 1; n <= 4; n++) begin
                    c = STRICT ? n - 1 : (m_last + n) % 4;
                    if (!got && elig[c]) begin
                        got = 1; m_burst = 1; m_owner = c;
                        m_left = weight(c); m_gnt = 4'(1 << c);
                    end
                end
            end
        end else begin
            if (popped) m_left--;
            if ((popped && m_left == 0) || !elig[m_owner] || !enable) begin
                m_burst = 0; m_last = m_owner; m_gnt = 4'b0;
            end
        end
        m_paused = (m_paused & ~continue_stb) | pause_stb;
    endtask

    // One clock cycle: predict and check pop, clock, then check registered outputs.
    task automatic step();
        logic [3:0] ep;
        int         id;
        #1;
        ep = model_pop();
        m_pop = ep;
        seen_pop = pop;
        check("pop", 32'(pop), 32'(ep));
        if (ep != 4'b0) exp_q.push_back(enc(ep));
        @(posedge CLK);
        model_edge();
        #1;
        check("valid_out", 32'(valid_out), 32'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                id = exp_q.pop_front();
                check("vc_id", 32'(vc_id), 32'(id));
            end
        end else begin
            check("vc_id_hold", 32'(vc_id), 32'(m_vc));
        end
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("paused", 32'(paused), 32'(m_paused));
    endtask

    // Run cycles until the model starts a burst on channel ch with a full budget (bounded).
    task automatic wait_burst_start(input int ch);
        bit hit;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_burst && m_owner == ch && m_left == weight(ch)) hit = 1;
            else step();
        end
        if (!hit) check("wait_timeout", 32'(0), 32'(1));
    endtask

    int n1;
    logic [3:0] seq_exp [17];
    logic [3:0] stall_exp [9];
    bit         stall_rdy [9];

    initial begin
        m_burst = 0; m_owner = 0; m_left = 0; m_last = 3;
        m_gnt = 0; m_paused = 0; m_pop = 0; m_valid = 0; m_vc = 0;
        reset = 1'b1; enable = 1'b1; empty = 4'b0; out_ready = 1'b1;
        pause_stb = 4'b0; continue_stb = 4'b0;
        @(posedge CLK); #1;
        step(); step();
        check("gnt_reset", 32'(gnt), 32'(0));
        check("vc_id_reset", 32'(vc_id), 32'(0));
        check("valid_reset", 32'(valid_out), 32'(0));

        // Test 1: all FIFOs non-empty, out_ready high, default weights.
        if (STRICT) seq_exp = '{0,1,1,1,1,0,1,1,1,1,0,1,1,1,1,0,1};
        else        seq_exp = '{0,1,1,1,1,0,2,2,0,4,0,8,0,1,1,1,1};
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            check("wrr_seq", 32'(seen_pop), 32'(seq_exp[i]));
        end

        // Test 2: pause channel 1 during a ch0 burst, then resume it.
        wait_burst_start(0);
        pause_stb = 4'b0010; step(); pause_stb = 4'b0;
        check("paused_set", 32'(paused), 32'(4'b0010));
        n1 = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (seen_pop[1]) n1++;
        end
        check("ch1_skipped", 32'(n1), 32'(0));
        continue_stb = 4'b0010; step(); continue_stb = 4'b0;
        check("paused_clr", 32'(paused), 32'(0));
        n1 = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (seen_pop[1]) n1++;
        end
        if (!STRICT) check("ch1_resumed", 32'(n1 != 0), 32'(1));

        // Test 3: out_ready low for 3 cycles after two ch0 pops.
        stall_rdy = '{1,1,0,0,0,1,1,1,1};
        stall_exp = '{1,1,0,0,0,1,1,0,(STRICT ? 4'd1 : 4'd2)};
        wait_burst_start(0);
        for (int i = 0; i < 9; i++) begin
            out_ready = stall_rdy[i];
            step();
            check("stall_seq", 32'(seen_pop), 32'(stall_exp[i]));
            if (i == 3) check("stall_gnt", 32'(gnt), 32'(4'b0001));
        end
        out_ready = 1'b1;

        // Test 4: ch0 empties mid-burst; then pause and continue together.
        wait_burst_start(0);
        step(); step();
        empty = 4'b0001;
        step();
        check("empty_exit_gnt", 32'(gnt), 32'(0));
        step();
        check("empty_next_gnt", 32'(gnt), 32'(4'b0010));
        empty = 4'b0000;
        pause_stb = 4'b0100; continue_stb = 4'b0100;
        step();
        pause_stb = 4'b0; continue_stb = 4'b0;
        check("pause_wins", 32'(paused[2]), 32'(1));
        continue_stb = 4'b0100; step(); continue_stb = 4'b0;

        // Test 5: reset in the middle of a ch1 burst.
        pause_stb = 4'b1000; step(); pause_stb = 4'b0;
        empty = 4'b0001;
        wait_burst_start(1);
        step();
        empty = 4'b0000;
        reset = 1'b1;
        step();
        check("reset_pop", 32'(seen_pop), 32'(0));
        check("reset_paused", 32'(paused), 32'(0));
        check("reset_gnt", 32'(gnt), 32'(0));
        reset = 1'b0;
        step();
        check("first_grant", 32'(gnt), 32'(4'b0001));

        // Test 6: enable drops mid-burst.
        step();
        enable = 1'b0;
        step();
        check("disable_pop", 32'(seen_pop), 32'(0));
        check("disable_gnt", 32'(gnt), 32'(0));
        step();
        check("disable_idle", 32'(gnt), 32'(0));
        enable = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            enable       = ($urandom_range(0, 15) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            empty        = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            pause_stb    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            continue_stb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            reset        = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0; pause_stb = 4'b0; continue_stb = 4'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
